// File: rtl/alu_seq.sv
// alu_seq: handshaked N-bit ALU with registered zero/negative/carry/overflow flags.
// Define ALU_MULDIV_EN to build the iterative MUL/DIVU/REMU unit; otherwise those codes are illegal.
module alu_seq #(
   parameter  int N   = 32,
   localparam int SHW = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic [3:0]   op,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] y,
   output logic         zero_f,
   output logic         neg_f,
   output logic         carry_f,
   output logic         ovf_f
);

   typedef enum logic [3:0] {
      OP_AND  = 4'b0001,
      OP_OR   = 4'b0010,
      OP_XOR  = 4'b0111,
      OP_ADD  = 4'b0100,
      OP_SUB  = 4'b1001,
      OP_SLT  = 4'b1100,
      OP_SLTU = 4'b1101,
      OP_SLL  = 4'b0011,
      OP_SRL  = 4'b1010,
      OP_SRA  = 4'b1011,
      OP_MUL  = 4'b1110,
      OP_DIVU = 4'b1111,
      OP_REMU = 4'b0110
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
`ifdef ALU_MULDIV_EN
      S_BUSY = 2'd3,
`endif
      S_DONE = 2'd2
   } state_e;

   state_e       state_q, state_d;
   op_e          op_q;
   logic [N-1:0] a_q, b_q;
   logic [N-1:0] y_q, y_d;
   logic         zero_q, zero_d, neg_q, neg_d, carry_q, carry_d, ovf_q, ovf_d;
   logic         accept, load_res;
   logic [N:0]   add_w, sub_w;

`ifdef ALU_MULDIV_EN
   localparam int CNT_W = SHW + 1;
   logic [CNT_W-1:0] cnt_q;
   logic [N-1:0]     p_q, p_d, x_q, x_d, d_q, d_d;
   logic [N:0]       rem_sh, trial;
`endif

   assign accept    = in_valid && (state_q == S_IDLE);
   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign y         = y_q;
   assign zero_f    = zero_q;
   assign neg_f     = neg_q;
   assign carry_f   = carry_q;
   assign ovf_f     = ovf_q;

   // NOTE: every signal driven here gets a default first, so no path can infer a latch.
   always_comb begin
      state_d  = state_q;
      load_res = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
`ifdef ALU_MULDIV_EN
               if (op inside {OP_MUL, OP_DIVU, OP_REMU}) state_d = S_BUSY;
               else
`endif
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            state_d  = S_DONE;
            load_res = 1'b1;
         end
`ifdef ALU_MULDIV_EN
         S_BUSY: begin
            if (cnt_q == CNT_W'(N)) begin
               state_d  = S_DONE;
               load_res = 1'b1;
            end
         end
`endif
         S_DONE: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // NOTE: operand and iteration registers have no reset; they are always loaded on accept before use.
   always_ff @(posedge clk) begin
      if (accept) begin
         a_q  <= a;
         b_q  <= b;
         op_q <= op_e'(op);
      end
   end

`ifdef ALU_MULDIV_EN
   // p: product accumulator / partial remainder; x: shifted multiplicand / dividend-into-quotient.
   always_comb begin
      rem_sh = {p_q, x_q[N-1]};
      trial  = rem_sh - {1'b0, d_q};
      p_d    = p_q;
      x_d    = x_q;
      d_d    = d_q;
      if (op_q == OP_MUL) begin
         if (d_q[0]) p_d = p_q + x_q;
         x_d = x_q << 1;
         d_d = d_q >> 1;
      end else if (!trial[N]) begin
         p_d = trial[N-1:0];
         x_d = {x_q[N-2:0], 1'b1};
      end else begin
         p_d = rem_sh[N-1:0];
         x_d = {x_q[N-2:0], 1'b0};
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         p_q   <= '0;
         x_q   <= a;
         d_q   <= b;
         cnt_q <= '0;
      end else if (state_q == S_BUSY && cnt_q != CNT_W'(N)) begin
         p_q   <= p_d;
         x_q   <= x_d;
         d_q   <= d_d;
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end
`endif

   always_comb begin
      add_w   = {1'b0, a_q} + {1'b0, b_q};
      sub_w   = {1'b0, a_q} - {1'b0, b_q};
      y_d     = '0;
      carry_d = 1'b0;
      ovf_d   = 1'b0;
      case (op_q)
         OP_AND:  y_d = a_q & b_q;
         OP_OR:   y_d = a_q | b_q;
         OP_XOR:  y_d = a_q ^ b_q;
         OP_ADD: begin
            y_d     = add_w[N-1:0];
            carry_d = add_w[N];
            ovf_d   = (a_q[N-1] == b_q[N-1]) && (add_w[N-1] != a_q[N-1]);
         end
         OP_SUB: begin
            y_d     = sub_w[N-1:0];
            carry_d = ~sub_w[N];
            ovf_d   = (a_q[N-1] != b_q[N-1]) && (sub_w[N-1] != a_q[N-1]);
         end
         OP_SLT:  y_d = {{(N-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
         OP_SLTU: y_d = {{(N-1){1'b0}}, (a_q < b_q)};
         OP_SLL:  y_d = a_q << b_q[SHW-1:0];
         OP_SRL:  y_d = a_q >> b_q[SHW-1:0];
         OP_SRA:  y_d = $signed(a_q) >>> b_q[SHW-1:0];
`ifdef ALU_MULDIV_EN
         OP_MUL, OP_REMU: y_d = p_q;
         OP_DIVU:         y_d = x_q;
`endif
         default: y_d = '0;
      endcase
      zero_d = (y_d == '0);
      neg_d  = y_d[N-1];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         y_q     <= '0;
         zero_q  <= 1'b0;
         neg_q   <= 1'b0;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else if (load_res) begin
         y_q     <= y_d;
         zero_q  <= zero_d;
         neg_q   <= neg_d;
         carry_q <= carry_d;
         ovf_q   <= ovf_d;
      end
   end

endmodule
